// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_sequencer
// Purpose  : Triangular duty-cycle fade (up, hold, down, hold) for a PWM core,
//            updating duty only on PWM period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_sequencer #(
    parameter int DUTY_W = 8,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              stop,
    input  logic [DUTY_W-1:0] step,
    input  logic [DUTY_W-1:0] max_duty,
    input  logic [HOLD_W-1:0] hold_periods,
    input  logic              period_done,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_load,
    output logic              busy,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD_HI = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    localparam logic [DUTY_W-1:0] c_step_one = {{(DUTY_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] c_hold_one = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [DUTY_W-1:0] r_duty;
    logic              r_duty_load;
    logic              r_busy;
    logic              r_stop_pending;
    logic [DUTY_W-1:0] r_step;
    logic [DUTY_W-1:0] r_max;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [DUTY_W:0]   w_sum;
    logic              w_sat;
    logic              w_stop_now;
    logic              w_hold_done;

    // One extra bit so the ramp-up sum cannot wrap before the saturation test
    assign w_sum       = {1'b0, r_duty} + {1'b0, r_step};
    assign w_sat       = (w_sum >= {1'b0, r_max});
    assign w_stop_now  = r_stop_pending | stop;
    assign w_hold_done = (r_hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_duty         <= '0;
            r_duty_load    <= 1'b0;
            r_busy         <= 1'b0;
            r_stop_pending <= 1'b0;
            r_step         <= '0;
            r_max          <= '0;
            r_hold         <= '0;
            r_hold_cnt     <= '0;
        end else if (ena) begin
            r_duty_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_step  <= (step == '0) ? c_step_one : step;
                        r_max   <= max_duty;
                        r_hold  <= hold_periods;
                        r_state <= S_UP;
                        r_busy  <= 1'b1;
                    end
                end
                S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (period_done) begin
                        if (w_stop_now) begin
                            r_duty         <= '0;
                            r_duty_load    <= 1'b1;
                            r_state        <= S_IDLE;
                            r_busy         <= 1'b0;
                            r_stop_pending <= 1'b0;
                        end else begin
                            case (r_state)
                                S_UP: begin
                                    r_duty_load <= 1'b1;
                                    if (w_sat) begin
                                        r_duty     <= r_max;
                                        r_hold_cnt <= r_hold;
                                        r_state    <= S_HOLD_HI;
                                    end else begin
                                        r_duty <= w_sum[DUTY_W-1:0];
                                    end
                                end
                                S_HOLD_HI: begin
                                    if (w_hold_done) begin
                                        r_state <= S_DOWN;
                                    end else begin
                                        r_hold_cnt <= r_hold_cnt - c_hold_one;
                                    end
                                end
                                S_DOWN: begin
                                    r_duty_load <= 1'b1;
                                    if (r_duty <= r_step) begin
                                        r_duty     <= '0;
                                        r_hold_cnt <= r_hold;
                                        r_state    <= S_HOLD_LO;
                                    end else begin
                                        r_duty <= r_duty - r_step;
                                    end
                                end
                                default: begin
                                    if (w_hold_done) begin
                                        r_state <= S_UP;
                                    end else begin
                                        r_hold_cnt <= r_hold_cnt - c_hold_one;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_busy         <= 1'b0;
                    r_stop_pending <= 1'b0;
                end
            endcase
        end else begin
            r_duty_load <= 1'b0;
        end
    end

    assign duty      = r_duty;
    assign duty_load = r_duty_load;
    assign busy      = r_busy;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_sequencer
// Purpose  : Self-checking bench; expected outputs come from a per-event
//            schedule of the whole fade cycle built from its parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, stop, period_done;
    logic [7:0] step, max_duty, hold_periods;
    logic [7:0] duty;
    logic       duty_load, busy;
    logic [2:0] state;

    pwm_fade_sequencer #(.DUTY_W(8), .HOLD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
        .step(step), .max_duty(max_duty), .hold_periods(hold_periods),
        .period_done(period_done), .duty(duty), .duty_load(duty_load),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: one entry per event of a full fade cycle, giving the outputs after it
    typedef struct { int duty; bit load; int st; } ev_t;
    ev_t sched[$];
    int  m_idx, m_duty, m_state;
    bit  m_load, m_busy, m_pend;

    task automatic build(input int s_in, input int mx, input int hd);
        int s, d;
        s = (s_in == 0) ? 1 : s_in;
        d = 0;
        sched.delete();
        while (1) begin
            if (d + s >= mx) begin d = mx; sched.push_back('{d, 1'b1, 2}); break; end
            d += s; sched.push_back('{d, 1'b1, 1});
        end
        for (int i = 0; i <= hd; i++) sched.push_back('{d, 1'b0, (i == hd) ? 3 : 2});
        while (1) begin
            if (d <= s) begin d = 0; sched.push_back('{0, 1'b1, 4}); break; end
            d -= s; sched.push_back('{d, 1'b1, 3});
        end
        for (int i = 0; i <= hd; i++) sched.push_back('{0, 1'b0, (i == hd) ? 1 : 4});
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_duty = 0; m_load = 0; m_busy = 0; m_state = 0; m_pend = 0; m_idx = 0;
        end else if (!ena) begin
            m_load = 0;
        end else begin
            m_load = 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    build(step, max_duty, hold_periods);
                    m_busy = 1; m_state = 1; m_idx = 0; m_pend = 0;
                end
            end else begin
                if (stop) m_pend = 1;
                if (period_done) begin
                    if (m_pend) begin
                        m_duty = 0; m_load = 1; m_state = 0; m_busy = 0; m_pend = 0;
                    end else begin
                        m_duty  = sched[m_idx].duty;
                        m_load  = sched[m_idx].load;
                        m_state = sched[m_idx].st;
                        m_idx   = (m_idx + 1) % sched.size();
                    end
                end
            end
        end
    endtask

    bit  rec_on = 0;
    int  rec[$];

    task automatic cycle(input bit pd, input bit st, input bit sp);
        period_done = pd; start = st; stop = sp;
        @(posedge clk);
        model_update();
        #1;
        check("duty", duty, m_duty);
        check("duty_load", duty_load, m_load);
        check("state", state, m_state);
        check("busy", busy, m_busy);
        if (rec_on && duty_load) rec.push_back(duty);
        period_done = 0; start = 0; stop = 0;
    endtask

    task automatic run_events(input int n, input int gap);
        repeat (n) begin
            repeat (gap - 1) cycle(0, 0, 0);
            cycle(1, 0, 0);
        end
    endtask

    task automatic cfg(input int s, input int mx, input int hd);
        step = 8'(s); max_duty = 8'(mx); hold_periods = 8'(hd);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[9] = '{64, 128, 192, 200, 136, 72, 8, 0, 64};
        rst_n = 0; ena = 1; start = 0; stop = 0; period_done = 0;
        cfg(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 1, 0);
        rst_n = 1;
        cycle(0, 0, 0);

        // Full cycle with inputs altered after start to prove latching
        cfg(64, 200, 1);
        cycle(0, 1, 0);
        cfg(7, 9, 5);
        rec_on = 1;
        run_events(13, 16);
        rec_on = 0;
        check("seq_len", rec.size(), 9);
        for (int i = 0; i < 9 && i < rec.size(); i++) check("seq_val", rec[i], exp_seq[i]);

        // Reset mid-UP
        run_events(1, 16);
        check("pre_rst_duty", duty, 128);
        rst_n = 0;
        cycle(1, 0, 0);
        check("rst_state", state, 0);
        check("rst_duty", duty, 0);
        cycle(0, 0, 0);
        rst_n = 1;
        cycle(0, 0, 0);

        // Corner values
        cfg(0, 3, 0);
        cycle(0, 1, 0);
        run_events(3, 2);
        check("step0_duty", duty, 3);
        cycle(1, 0, 1);
        cfg(255, 255, 0);
        cycle(0, 1, 0);
        run_events(1, 3);
        check("full_duty", duty, 255);
        cycle(1, 0, 1);
        cfg(10, 0, 0);
        cycle(0, 1, 0);
        run_events(1, 3);
        check("max0_state", state, 2);
        check("max0_duty", duty, 0);
        cycle(1, 0, 1);

        // Stop in HOLD_HI, applied at the later event, then coincident with event
        cfg(64, 200, 3);
        cycle(0, 1, 0);
        run_events(4, 4);
        check("hold_duty", duty, 200);
        cycle(0, 0, 1);
        repeat (9) cycle(0, 0, 0);
        check("stop_wait_busy", busy, 1);
        cycle(1, 0, 0);
        check("stop_busy", busy, 0);
        check("stop_load", duty_load, 1);
        cycle(0, 1, 0);
        run_events(4, 4);
        cycle(1, 0, 1);
        check("stop_coinc_state", state, 0);

        // ena gating
        cfg(64, 200, 1);
        cycle(0, 1, 0);
        run_events(2, 4);
        ena = 0;
        run_events(3, 4);
        cycle(1, 1, 1);
        check("ena_hold_duty", duty, 128);
        ena = 1;
        run_events(1, 4);
        check("ena_resume", duty, 192);
        cycle(1, 0, 1);

        // start while busy and start+stop in IDLE
        cycle(0, 1, 0);
        run_events(1, 3);
        cfg(1, 255, 0);
        cycle(0, 1, 0);
        run_events(1, 3);
        check("busy_start_ign", duty, 128);
        cycle(1, 0, 1);
        cycle(0, 1, 1);
        check("start_stop_idle", busy, 0);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) step = 8'($urandom_range(0, 3));
            cycle(0, 1, 0);
            repeat ($urandom_range(40, 160)) begin
                ena   = ($urandom_range(0, 9) != 0);
                rst_n = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 4) == 0) cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4));
                cycle($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 79) == 0);
            end
            ena = 1; rst_n = 1;
            cycle(1, 0, 1);
            check("rand_idle", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Controller for the PWM output stage.
- Drives the PWM core's duty-cycle register through a programmable triangular fade: ramp up, hold at the top, ramp down, hold at zero, repeat.
- Updates duty only at PWM period boundaries, signalled by the core's period_done pulse, so the PWM output never glitches mid-period.
- Sits between the configuration inputs (ui_in/uio_in) and the PWM counter/comparator in the top-level.

Parameters:
- DUTY_W, 8, width of duty, step and max_duty.
- HOLD_W, 8, width of the hold-period counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  design enable; low freezes all state.
- start  in  1  one-cycle request to begin fading.
- stop  in  1  one-cycle request to end fading.
- step  in  DUTY_W  duty increment/decrement per period.
- max_duty  in  DUTY_W  top duty level.
- hold_periods  in  HOLD_W  extra periods to dwell at top/bottom.
- period_done  in  1  one-cycle pulse from the PWM core at counter wrap.
- duty  out  DUTY_W  duty value to the PWM core.
- duty_load  out  1  one-cycle strobe: duty changed this cycle.
- busy  out  1  high while not IDLE.
- state  out  3  current state encoding (debug).

Behaviour:
- Clock/reset: single clock clk. rst_n is synchronous and active-low. Reset takes effect at the next clk edge, including mid-fade.
- Reset values: duty=0, duty_load=0, busy=0, state=IDLE; all internal latches and counters cleared.
- State encodings: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4. Codes 5-7 are unreachable and map to IDLE.
- ena=0: no state, duty or counter change; start, stop and period_done are all ignored; duty_load=0.
- Event: an "event" is a clk edge with ena=1 and period_done=1. duty and duty_load are registered, so they change on the edge after period_done is sampled. duty_load is high for exactly that one cycle and low otherwise.
- IDLE + start (ena=1):
  - Latch step, max_duty and hold_periods. A latched step of 0 is treated as 1.
  - Go to UP on the same edge; busy=1 from the next cycle.
  - Inputs changed while busy have no effect until the next start.
- start while busy: ignored.
- IDLE, start and stop together: stop wins; stay in IDLE.
- UP, on event:
  - Compute duty+step at DUTY_W+1 bits.
  - If the sum >= max: duty=max, load hold counter with hold, go to HOLD_HI.
  - Otherwise duty += step.
  - duty_load=1 in both cases.
- HOLD_HI, on event:
  - Counter==0: go to DOWN. Otherwise decrement the counter.
  - duty unchanged, duty_load=0.
  - Dwell is hold+1 events.
- DOWN, on event:
  - If duty <= step: duty=0, reload counter, go to HOLD_LO.
  - Otherwise duty -= step.
  - duty_load=1 in both cases. No underflow is possible.
- HOLD_LO, on event: same counter rule as HOLD_HI; on exit go to UP. Loops until stop.
- stop while busy:
  - Sets stop_pending; repeated stop pulses are idempotent.
  - At the next event in any non-IDLE state: duty=0, duty_load=1 (even if duty was already 0), go to IDLE, busy=0, stop_pending cleared.
  - stop and period_done on the same edge: the stop applies on that edge.
- max=0: the first UP event saturates to duty=0 with duty_load=1 and enters HOLD_HI.
- Arithmetic is unsigned throughout. No output changes except on events, start, stop or reset.
- Implementation size: 150-250 lines of RTL.

Test Plan:
1. Reset: rst_n=0 for 2 clks mid-UP, then rst_n=1 -> duty=0, duty_load=0, busy=0, state=0 on the first edge with rst_n low.
2. Full cycle: step=64, max=200, hold=1, period_done every 16 clks, start -> duty 64, 128, 192, 200 (one duty_load per event), 2 events in HOLD_HI, then 136, 72, 8, 0, 2 events in HOLD_LO, then 64 again; duty changes only on the clk after period_done.
3. Saturation and corner values: step=0, max=3 -> duty 1, 2, 3; step=255, max=255 -> duty 255 on the first event; max=0 -> duty stays 0 and state goes to 2 after the first event.
4. Stop: stop pulsed while in HOLD_HI with duty=200, next period_done 10 clks later -> no change for 10 clks, then duty=0, duty_load=1, state=0, busy=0. Repeat with stop coincident with period_done -> applied on that edge.
5. ena gating: ena=0 across 3 period_done pulses in UP at duty=128 -> duty stays 128, no duty_load. ena=1 -> next event gives 192.
6. Handshake misuse: start while busy with new step=1 -> ignored, 64-step sequence continues. start and stop together in IDLE -> busy stays 0.
